// File: rtl/or1200_rst_seq_pkg.sv
// Shared state encoding and parameter sanity helpers for the
// or1200_rst_seq reset sequencer.
package or1200_rst_seq_pkg;

  localparam logic [1:0] ST_HOLD     = 2'd0;
  localparam logic [1:0] ST_RELEASE  = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_EXPIRED  = 2'd3;

  typedef enum logic [1:0] {
    S_HOLD     = ST_HOLD,
    S_RELEASE  = ST_RELEASE,
    S_RUN      = ST_RUN,
    S_EXPIRED  = ST_EXPIRED
  } state_e;

  // True when a w-bit counter can hold both the last release
  // point and the watchdog limit.
  function automatic bit cnt_w_ok(
    input int unsigned w,
    input int unsigned dly,
    input int unsigned nch,
    input int unsigned stg,
    input int unsigned tmo
  );
    longint unsigned need;
    longint unsigned cap;
    need = longint'(dly) + longint'(nch) * longint'(stg);
    if (longint'(tmo) > need) need = longint'(tmo);
    if (w >= 63) return 1'b1;
    cap = (64'd1 << w) - 64'd1;
    return need <= cap;
  endfunction

endpackage

// File: rtl/or1200_rst_seq_if.sv
// Reset sequencer bundle: software request in, per-channel resets,
// ready, watchdog flag and run-cycle count out.
interface or1200_rst_seq_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);

  logic              sw_rst_i;
  logic [NUM_CH-1:0] rst_o;
  logic              ready_o;
  logic              timeout_o;
  logic [CNT_W-1:0]  cycle_cnt_o;

  modport master (
    output sw_rst_i,
    input  rst_o,
    input  ready_o,
    input  timeout_o,
    input  cycle_cnt_o
  );

  modport slave (
    input  sw_rst_i,
    output rst_o,
    output ready_o,
    output timeout_o,
    output cycle_cnt_o
  );

endinterface

// File: rtl/or1200_rst_seq_sync2.sv
// or1200_sync2: 2-flop synchroniser, flops cleared by rst_i.
// Ports: clk_i, rst_i, d_i (async in), q_o (synchronised out).
// Only built when OR1200_RST_SEQ_SYNC_REQ_EN is defined.
`ifdef OR1200_RST_SEQ_SYNC_REQ_EN
module or1200_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule
`endif

// File: rtl/or1200_rst_seq.sv
// Staggered reset sequencer + run watchdog. Ports: clk_i, rst_i
// (async, active-high), bus (slave: sw_rst_i, rst_o, ready_o,
// timeout_o, cycle_cnt_o). OR1200_RST_SEQ_SYNC_REQ_EN adds a
// 2-flop synchroniser on sw_rst_i.
module or1200_rst_seq
  import or1200_rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DLY_CYC     = 10,
  parameter int STAGGER_CYC = 2,
  parameter int TIMEOUT_CYC = 200,
  parameter int CNT_W       = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  or1200_rst_seq_if.slave bus
);

  localparam int LAST = DLY_CYC + (NUM_CH - 1) * STAGGER_CYC;

  localparam logic [CNT_W-1:0] DLY_V = CNT_W'(DLY_CYC);
  localparam logic [CNT_W-1:0] RDY_V = CNT_W'(LAST + 1);
  localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT_CYC - 1);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("or1200_rst_seq: NUM_CH out of range");
  end

  if (!cnt_w_ok(CNT_W, DLY_CYC, NUM_CH,
                STAGGER_CYC, TIMEOUT_CYC)) begin : g_bad_cnt_w
    $error("or1200_rst_seq: CNT_W too narrow");
  end

  logic sw_req;

`ifdef OR1200_RST_SEQ_SYNC_REQ_EN
  or1200_sync2 u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (bus.sw_rst_i),
    .q_o   (sw_req)
  );
`else
  assign sw_req = bus.sw_rst_i;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  seq_q, seq_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              rdy_q, rdy_d;
  logic              to_q, to_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_HOLD;
      seq_q   <= '0;
      cnt_q   <= '0;
      rst_q   <= '1;
      rdy_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      rdy_q   <= rdy_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    rdy_d   = rdy_q;
    to_d    = to_q;
    if (sw_req) begin
      state_d = S_HOLD;
      seq_d   = '0;
      cnt_d   = '0;
      rst_d   = '1;
      rdy_d   = 1'b0;
      to_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD, S_RELEASE: begin
          seq_d = seq_q + 1'b1;
          // Bits only ever clear here, so the >= keeps
          // released channels released.
          for (int k = 0; k < NUM_CH; k++) begin
            if (seq_q >= CNT_W'(DLY_CYC + k * STAGGER_CYC))
              rst_d[k] = 1'b0;
          end
          if (state_q == S_HOLD) begin
            if (seq_q == DLY_V) state_d = S_RELEASE;
          end else if (seq_q == RDY_V) begin
            state_d = S_RUN;
            rdy_d   = 1'b1;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          if (TIMEOUT_CYC != 0 && cnt_q == TO_M1) begin
            state_d = S_EXPIRED;
            to_d    = 1'b1;
            cnt_d   = TO_V;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_EXPIRED: begin
        end
        default: state_d = S_HOLD;
      endcase
    end
  end

  assign bus.rst_o       = rst_q;
  assign bus.ready_o     = rdy_q;
  assign bus.timeout_o   = to_q;
  assign bus.cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_or1200_rst_seq.sv
// Directed bench for or1200_rst_seq: default config plus a
// saturating (no watchdog) config and a single-channel config.
module tb_or1200_rst_seq;

`ifdef OR1200_RST_SEQ_SYNC_REQ_EN
  localparam int LAG = 2;
`else
  localparam int LAG = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   e = -1;

  always #5 clk = ~clk;

  or1200_rst_seq_if #(.NUM_CH(4), .CNT_W(16)) ifa ();
  or1200_rst_seq_if #(.NUM_CH(4), .CNT_W(4))  ifb ();
  or1200_rst_seq_if #(.NUM_CH(1), .CNT_W(8))  ifc ();

  or1200_rst_seq u_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa.slave)
  );

  or1200_rst_seq #(
    .NUM_CH(4), .DLY_CYC(3), .STAGGER_CYC(1),
    .TIMEOUT_CYC(0), .CNT_W(4)
  ) u_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb.slave)
  );

  or1200_rst_seq #(
    .NUM_CH(1), .DLY_CYC(3), .STAGGER_CYC(1),
    .TIMEOUT_CYC(5), .CNT_W(8)
  ) u_c (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic start_seq();
    rst = 1'b1;
    ifa.sw_rst_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    e = -1;
  endtask

  task automatic test_reset();
    ifa.sw_rst_i = 1'b0;
    ifb.sw_rst_i = 1'b0;
    ifc.sw_rst_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (ifa.rst_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_rst_o: got %b want 1111", ifa.rst_o);
    end
    n_chk++;
    if (ifa.ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 0", ifa.ready_o);
    end
    n_chk++;
    if (ifa.timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_timeout: got %b want 0", ifa.timeout_o);
    end
    n_chk++;
    if (ifa.cycle_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", ifa.cycle_cnt_o);
    end
    n_chk++;
    if (ifb.rst_o !== 4'b1111 || ifc.rst_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_small: got %b/%b want 1111/1",
               ifb.rst_o, ifc.rst_o);
    end
  endtask

  task automatic test_release();
    logic [3:0] exp;
    start_seq();
    for (int n = 0; n <= 20; n++) begin
      tick();
      for (int k = 0; k < 4; k++) exp[k] = (e < 10 + 2 * k);
      n_chk++;
      if (ifa.rst_o !== exp) begin
        n_fail++;
        $display("FAIL release_rst_o E%0d: got %b want %b",
                 e, ifa.rst_o, exp);
      end
      n_chk++;
      if (ifa.ready_o !== (e >= 17)) begin
        n_fail++;
        $display("FAIL release_ready E%0d: got %b want %b",
                 e, ifa.ready_o, (e >= 17));
      end
    end
    n_chk++;
    if (ifa.cycle_cnt_o !== 16'd3) begin
      n_fail++;
      $display("FAIL release_cnt E20: got %0d want 3",
               ifa.cycle_cnt_o);
    end
  endtask

  task automatic test_timeout();
    while (e < 216) tick();
    n_chk++;
    if (ifa.timeout_o !== 1'b0 || ifa.cycle_cnt_o !== 16'd199) begin
      n_fail++;
      $display("FAIL pre_timeout E216: got to=%b cnt=%0d want 0/199",
               ifa.timeout_o, ifa.cycle_cnt_o);
    end
    tick();
    n_chk++;
    if (ifa.timeout_o !== 1'b1 || ifa.cycle_cnt_o !== 16'd200) begin
      n_fail++;
      $display("FAIL timeout E217: got to=%b cnt=%0d want 1/200",
               ifa.timeout_o, ifa.cycle_cnt_o);
    end
    repeat (50) begin
      tick();
      n_chk++;
      if (ifa.cycle_cnt_o !== 16'd200 || ifa.timeout_o !== 1'b1 ||
          ifa.rst_o !== 4'b0000 || ifa.ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL expired_hold E%0d: got cnt=%0d to=%b rst=%b rdy=%b",
                 e, ifa.cycle_cnt_o, ifa.timeout_o, ifa.rst_o,
                 ifa.ready_o);
      end
    end
  endtask

  task automatic test_sw_expired();
    logic [3:0] exp;
    ifa.sw_rst_i = 1'b1;
    repeat (LAG) tick();
    repeat (2) begin
      tick();
      n_chk++;
      if (ifa.rst_o !== 4'b1111 || ifa.timeout_o !== 1'b0 ||
          ifa.ready_o !== 1'b0 || ifa.cycle_cnt_o !== 16'd0) begin
        n_fail++;
        $display("FAIL sw_pin: got rst=%b to=%b rdy=%b cnt=%0d want 1111/0/0/0",
                 ifa.rst_o, ifa.timeout_o, ifa.ready_o,
                 ifa.cycle_cnt_o);
      end
    end
    ifa.sw_rst_i = 1'b0;
    repeat (LAG) tick();
    e = -1;
    for (int n = 0; n <= 17; n++) begin
      tick();
      for (int k = 0; k < 4; k++) exp[k] = (e < 10 + 2 * k);
      n_chk++;
      if (ifa.rst_o !== exp || ifa.ready_o !== (e >= 17) ||
          ifa.timeout_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reseq_exp E%0d: got rst=%b rdy=%b to=%b want %b/%b/0",
                 e, ifa.rst_o, ifa.ready_o, ifa.timeout_o, exp,
                 (e >= 17));
      end
    end
  endtask

  task automatic test_sw_run();
    logic [3:0] exp;
    while (e < 99) tick();
    ifa.sw_rst_i = 1'b1;
    tick();
    ifa.sw_rst_i = 1'b0;
    repeat (LAG) tick();
    n_chk++;
    if (ifa.rst_o !== 4'b1111 || ifa.ready_o !== 1'b0 ||
        ifa.cycle_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL sw_run_hit: got rst=%b rdy=%b cnt=%0d want 1111/0/0",
               ifa.rst_o, ifa.ready_o, ifa.cycle_cnt_o);
    end
    e = -1;
    for (int n = 0; n <= 17; n++) begin
      tick();
      for (int k = 0; k < 4; k++) exp[k] = (e < 10 + 2 * k);
      n_chk++;
      if (ifa.rst_o !== exp || ifa.ready_o !== (e >= 17)) begin
        n_fail++;
        $display("FAIL sw_run_reseq E%0d: got rst=%b rdy=%b want %b/%b",
                 e, ifa.rst_o, ifa.ready_o, exp, (e >= 17));
      end
    end
    n_chk++;
    if (ifa.cycle_cnt_o !== 16'd0) begin
      n_fail++;
      $display("FAIL sw_run_cnt E17: got %0d want 0", ifa.cycle_cnt_o);
    end
  endtask

  task automatic test_async_rst();
    start_seq();
    while (e < 12) tick();
    n_chk++;
    if (ifa.rst_o !== 4'b1100) begin
      n_fail++;
      $display("FAIL mid_release E12: got %b want 1100", ifa.rst_o);
    end
    #3;
    rst = 1'b1;
    #1;
    n_chk++;
    if (ifa.rst_o !== 4'b1111 || ifa.ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got rst=%b rdy=%b want 1111/0",
               ifa.rst_o, ifa.ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
    e = -1;
    while (e < 9) tick();
    n_chk++;
    if (ifa.rst_o !== 4'b1111) begin
      n_fail++;
      $display("FAIL async_reseq E9: got %b want 1111", ifa.rst_o);
    end
    tick();
    n_chk++;
    if (ifa.rst_o !== 4'b1110) begin
      n_fail++;
      $display("FAIL async_reseq E10: got %b want 1110", ifa.rst_o);
    end
  endtask

  task automatic test_small_cfg();
    logic [3:0] eb;
    int         cb;
    int         cc;
    start_seq();
    for (int n = 0; n <= 60; n++) begin
      tick();
      for (int k = 0; k < 4; k++) eb[k] = (e < 3 + k);
      cb = (e < 7) ? 0 : ((e - 7 > 15) ? 15 : e - 7);
      cc = (e < 4) ? 0 : ((e - 4 > 5) ? 5 : e - 4);
      n_chk++;
      if (ifb.rst_o !== eb || ifb.ready_o !== (e >= 7) ||
          ifb.cycle_cnt_o !== 4'(cb) || ifb.timeout_o !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_cfg E%0d: got rst=%b rdy=%b cnt=%0d to=%b want %b/%b/%0d/0",
                 e, ifb.rst_o, ifb.ready_o, ifb.cycle_cnt_o,
                 ifb.timeout_o, eb, (e >= 7), cb);
      end
      n_chk++;
      if (ifc.rst_o !== (e < 3) || ifc.ready_o !== (e >= 4) ||
          ifc.cycle_cnt_o !== 8'(cc) || ifc.timeout_o !== (e >= 9)) begin
        n_fail++;
        $display("FAIL one_ch E%0d: got rst=%b rdy=%b cnt=%0d to=%b want %b/%b/%0d/%b",
                 e, ifc.rst_o, ifc.ready_o, ifc.cycle_cnt_o,
                 ifc.timeout_o, (e < 3), (e >= 4), cc, (e >= 9));
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_timeout();
    test_sw_expired();
    test_sw_run();
    test_async_rst();
    test_small_cfg();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/or1200_rst_seq.md
Name: or1200_rst_seq

Overview:
- Parametrised reset sequencer and run-time watchdog for the or1200_sopc platform.
- Synthesisable successor to fixed clock/reset pulse generation: the hold time is programmable, and per-domain resets are released in a staggered order.
- Reports system ready, counts run cycles, and raises a sticky timeout after a programmable run length.
- Sits between the board reset and the CPU, bus and peripheral reset inputs.

Parameters:
- NUM_CH, 4: number of reset output channels (1..16).
- DLY_CYC, 10: cycles all channels are held in reset after sequence start (>=1).
- STAGGER_CYC, 2: cycles between successive channel releases (>=1).
- TIMEOUT_CYC, 200: RUN cycles before timeout_o asserts; 0 disables the watchdog.
- CNT_W, 16: width of the internal counters and cycle_cnt_o. Must hold max(DLY_CYC+NUM_CH*STAGGER_CYC, TIMEOUT_CYC).

Ports:
- clk_i  in  1  system clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- sw_rst_i  in  1  software re-sequence request, active-high, level.
- rst_o  out  NUM_CH  per-channel reset, active-high; channel 0 is released first.
- ready_o  out  1  high once all channels are released.
- timeout_o  out  1  sticky watchdog expiry flag.
- cycle_cnt_o  out  CNT_W  RUN-cycle count.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high on rst_i.
- Outputs while rst_i is high: rst_o all ones, ready_o 0, timeout_o 0, cycle_cnt_o 0. State is HOLD and the sequence counter is 0.
- Edge numbering: E0 is the first rising edge at which rst_i is low. All outputs are registered.
- States: HOLD -> RELEASE -> RUN -> EXPIRED.
- HOLD:
  - rst_o stays all ones.
  - The sequence counter increments from E0.
  - At E(DLY_CYC), rst_o[0] clears and the state goes to RELEASE.
- RELEASE:
  - rst_o[k] clears at E(DLY_CYC + k*STAGGER_CYC).
  - Once a channel clears it never re-asserts except via rst_i or sw_rst_i.
  - At E(DLY_CYC + (NUM_CH-1)*STAGGER_CYC + 1): ready_o is set, the state goes to RUN, and cycle_cnt_o reads 0.
- RUN:
  - cycle_cnt_o increments by 1 each edge.
  - If TIMEOUT_CYC>0 and the edge sees cycle_cnt_o == TIMEOUT_CYC-1: timeout_o is set, cycle_cnt_o becomes TIMEOUT_CYC, and the state goes to EXPIRED.
  - If TIMEOUT_CYC==0: the state never leaves RUN, and cycle_cnt_o saturates at all ones (no wrap).
- EXPIRED:
  - timeout_o stays 1, cycle_cnt_o is frozen, ready_o stays 1, rst_o stays released.
  - Exit only via rst_i or sw_rst_i.
- sw_rst_i (effective, i.e. after optional synchronisation):
  - Sampled high at any edge, in any state: next values are state HOLD, rst_o all ones, ready_o 0, timeout_o 0, cycle_cnt_o 0, sequence counter 0.
  - While it stays high, the block remains pinned in HOLD with the counter at 0.
  - The first edge sampling it low is the new E0.
- Precedence and glitch rules:
  - rst_i overrides everything, asynchronously.
  - sw_rst_i overrides timeout expiry on the same edge.
  - rst_o bits change only on clock edges or rst_i assertion; no combinational glitches.
- NUM_CH=1: the single channel clears at E(DLY_CYC); ready_o sets at E(DLY_CYC+1).

Optional Feature:
- Macro OR1200_RST_SEQ_SYNC_REQ_EN.
- Defined: sw_rst_i passes through a 2-flop synchroniser (flops reset to 0 by rst_i), so the effective request lags the pin by 2 edges.
- Undefined: sw_rst_i is treated as synchronous to clk_i and sampled directly, with no added latency.

Decomposition:
- Package or1200_rst_seq_pkg holds:
  - state encoding localparams ST_HOLD=2'd0, ST_RELEASE=2'd1, ST_RUN=2'd2, ST_EXPIRED=2'd3;
  - a width-check constant function used for CNT_W sanity checking.
- Sub-module or1200_sync2 is the 2-flop synchroniser (async active-high reset). It is instantiated only under OR1200_RST_SEQ_SYNC_REQ_EN.

Test Plan:
- Defaults, rst_i pulse: rst_o[0..3] clear at E10, E12, E14, E16; ready_o=1 at E17; no bit changes before E10.
- Defaults, free run: timeout_o rises at E217 with cycle_cnt_o=200; the count holds at 200 for 50 more cycles; rst_o stays 4'b0000.
- sw_rst_i pulsed 1 cycle at E100: next edge shows rst_o=4'b1111, ready_o=0, cycle_cnt_o=0; the release pattern repeats relative to the new E0.
- sw_rst_i asserted in EXPIRED: timeout_o clears, and a full re-sequence completes. Also assert rst_i mid-RELEASE, between clock edges: rst_o becomes 4'b1111 immediately, without waiting for a clock edge.
- TIMEOUT_CYC=0, CNT_W=4: cycle_cnt_o saturates at 15, and timeout_o stays 0 indefinitely.
- With OR1200_RST_SEQ_SYNC_REQ_EN: a sw_rst_i rise sampled at edge En gives rst_o=4'b1111 at E(n+2), versus E(n) without the macro.
